// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch (IF) and
// load/store (MEM) ports. One 8-bit RAM access per cycle, little-endian lane
// assembly, MEM has priority over IF.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global run enable (0 freezes everything, write strobe gated)
//   if_req_i/if_addr_i/if_abort_i   fetch request (always 4 bytes) / branch cancel
//   if_data_o/if_done_o             fetched word / one-cycle completion pulse
//   mem_req_i/mem_we_i/mem_addr_i/mem_wdata_i/mem_len_i  load/store request
//   mem_data_o/mem_done_o/mem_busy_o  load data / completion pulse / stall
//   ram_din_i/ram_dout_o/ram_a_o/ram_wr_o  byte RAM (read data valid one cycle
//                                          after its address)
//
// Optional feature: define MEMCTRL_IF_ABORT_EN to let if_abort_i cancel an
// in-flight fetch; otherwise if_abort_i is ignored.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_abort_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [1:0]        mem_len_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_done_o,
  output logic              mem_busy_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [1:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic              wr_q;
  logic              busy_q;

  logic [1:0]        lane;
  logic [1:0]        nxt_lane;
  logic              last;
  logic [ADDR_W-1:0] next_a;
  logic [31:0]       rdata_next;
  logic              abort_hit;

`ifdef MEMCTRL_IF_ABORT_EN
  assign abort_hit = if_abort_i;
`else
  logic unused_abort;
  assign abort_hit    = 1'b0;
  assign unused_abort = if_abort_i;
`endif

  // Read buffer with the byte arriving this cycle merged into its lane, so the
  // final byte and the done pulse can be registered on the same edge.
  always_comb begin
    lane       = cnt[1:0];
    nxt_lane   = lane + 2'd1;
    last       = (cnt == {1'b0, len_q});
    next_a     = addr_q + ADDR_W'(cnt + 3'd1);
    rdata_next = rbuf;
    rdata_next[{lane, 3'b000} +: 8] = ram_din_i;
  end

  // The write strobe is gated combinationally so a stall or reset drops it
  // without waiting for an edge; the registered copy re-issues the byte later.
  assign ram_wr_o   = wr_q & rdy;
  assign mem_busy_o = busy_q | (mem_req_i & (state == IF_RD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      if_data_o  <= '0;
      if_done_o  <= 1'b0;
      mem_data_o <= '0;
      mem_done_o <= 1'b0;
      ram_dout_o <= '0;
      ram_a_o    <= '0;
    end else if (rdy) begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          // A done pulse marks the turnaround cycle; nothing is accepted in it.
          if (!if_done_o && !mem_done_o) begin
            if (mem_req_i) begin
              addr_q  <= mem_addr_i;
              len_q   <= (mem_len_i == 2'd2) ? 2'd3 : mem_len_i;
              wdata_q <= mem_wdata_i;
              rbuf    <= '0;
              cnt     <= '0;
              ram_a_o <= mem_addr_i;
              busy_q  <= 1'b1;
              if (mem_we_i) begin
                state      <= MEM_WR;
                wr_q       <= 1'b1;
                ram_dout_o <= mem_wdata_i[7:0];
              end else begin
                state <= MEM_RD;
              end
            end else if (if_req_i) begin
              addr_q  <= if_addr_i;
              len_q   <= 2'd3;
              rbuf    <= '0;
              cnt     <= '0;
              ram_a_o <= if_addr_i;
              state   <= IF_RD;
            end
          end
        end
        IF_RD: begin
          if (abort_hit) begin
            state   <= IDLE;
            cnt     <= '0;
            ram_a_o <= '0;
          end else if (last) begin
            if_data_o <= rdata_next;
            if_done_o <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            ram_a_o   <= '0;
          end else begin
            rbuf    <= rdata_next;
            cnt     <= cnt + 3'd1;
            ram_a_o <= next_a;
          end
        end
        MEM_RD: begin
          if (last) begin
            mem_data_o <= rdata_next;
            mem_done_o <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            ram_a_o    <= '0;
          end else begin
            rbuf    <= rdata_next;
            cnt     <= cnt + 3'd1;
            ram_a_o <= next_a;
          end
        end
        MEM_WR: begin
          if (last) begin
            mem_done_o <= 1'b1;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            ram_dout_o <= '0;
            state      <= IDLE;
            cnt        <= '0;
            ram_a_o    <= '0;
          end else begin
            cnt        <= cnt + 3'd1;
            ram_a_o    <= next_a;
            ram_dout_o <= wdata_q[{nxt_lane, 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte RAM model answers the
// DUT; a separate golden byte map holds what memory should contain. Directed
// table vectors, hand sequences for priority/stall/reset/abort, then random
// transactions checked against the golden map.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_abort;
  logic [31:0] if_addr, if_data;
  logic        if_done;
  logic        mem_req, mem_we, mem_done, mem_busy;
  logic [31:0] mem_addr, mem_wdata, mem_data;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
    .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_len_i(mem_len),
    .mem_data_o(mem_data), .mem_done_o(mem_done), .mem_busy_o(mem_busy),
    .ram_din_i(ram_din), .ram_dout_o(ram_dout), .ram_a_o(ram_a), .ram_wr_o(ram_wr)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  gm  [logic [31:0]];
  int          wr_cnt = 0;
  int          npass = 0, ntot = 0;
  logic [31:0] last_if = '0, last_mem = '0;

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_gm(input logic [31:0] a);
    return gm.exists(a) ? gm[a] : 8'h00;
  endfunction

  // RAM: address presented after an edge, data valid before the next edge.
  always @(negedge clk) ram_din = rd_ram(ram_a);
  always @(posedge clk) if (ram_wr) begin
    ram[ram_a] = ram_dout;
    wr_cnt++;
  end

  function automatic int nbytes(input int kind, input logic [1:0] len);
    if (kind == 0) return 4;
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd_gm(a + 32'(i));
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // kind: 0 fetch, 1 load, 2 store. mode: 0 no stall, 1 random rdy, 2 three-cycle stall on byte 1.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd, input int mode, input logic [31:0] exp,
                         input string tag);
    int n, e, tc, stall_left, wr0;
    bit seen, stalled;
    n = nbytes(kind, len);
    wr0 = wr_cnt;
    rdy = 1'b1;
    if (kind == 0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = (kind == 2); mem_addr = addr; mem_len = len; mem_wdata = wd;
    end
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs: they must have been latched at acceptance
    if_req = 1'b0; mem_req = 1'b0;
    if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
    mem_len = 2'($urandom); mem_we = 1'($urandom);
    e = 0; tc = 0; stall_left = 0; stalled = 0;
    for (int k = 0; k < 200; k++) begin
      seen = (kind == 0) ? if_done : mem_done;
      if (seen) break;
      chk({tag, " ram_a"}, ram_a, addr + 32'(e));
      chk({tag, " ram_wr"}, {31'b0, ram_wr}, {31'b0, (kind == 2) && rdy});
      if (kind == 2 && rdy) chk({tag, " ram_dout"}, {24'b0, ram_dout}, {24'b0, wd[8*e +: 8]});
      chk({tag, " busy"}, {31'b0, mem_busy}, {31'b0, kind != 0});
      if (mode == 1) rdy = ($urandom % 4 != 0);
      else if (mode == 2) begin
        if (e == 1 && !stalled) begin stall_left = 3; stalled = 1; end
        rdy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else rdy = 1'b1;
      @(posedge clk);
      if (rdy) e++;
      tc++;
      @(negedge clk);
    end
    seen = (kind == 0) ? if_done : mem_done;
    chk({tag, " done"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      chk({tag, " latency"}, e, n);
      if (mode == 2) chk({tag, " stalled cycles"}, tc, n + 3);
      chk({tag, " ram_a idle"}, ram_a, 32'h0);
      chk({tag, " ram_wr idle"}, {31'b0, ram_wr}, 32'h0);
      chk({tag, " busy end"}, {31'b0, mem_busy}, 32'h0);
      if (kind == 0) begin
        chk({tag, " if_data"}, if_data, exp);
        chk({tag, " mem_data hold"}, mem_data, last_mem);
        last_if = exp;
      end else if (kind == 1) begin
        chk({tag, " mem_data"}, mem_data, exp);
        chk({tag, " if_data hold"}, if_data, last_if);
        last_mem = exp;
      end else begin
        chk({tag, " mem_data hold"}, mem_data, last_mem);
        chk({tag, " if_data hold"}, if_data, last_if);
      end
    end
    chk({tag, " write count"}, wr_cnt - wr0, (kind == 2) ? n : 0);
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done pulse"}, {30'b0, if_done, mem_done}, 32'h0);
  endtask

  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] wd, input int mode, input logic [31:0] exp,
                        input string tag);
    int n;
    n = nbytes(kind, len);
    run_txn(kind, addr, len, wd, mode, exp, tag);
    if (kind == 2) begin
      for (int i = 0; i < n; i++) begin
        gm[addr + 32'(i)] = wd[8*i +: 8];
        chk({tag, " stored byte"}, {24'b0, rd_ram(addr + 32'(i))}, {24'b0, rd_gm(addr + 32'(i))});
      end
    end
  endtask

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   pulses;

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 0; if_abort = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_len = 0;
    ram_din = 0;

    // memory image, mirrored into the golden map
    begin
      logic [7:0] img [4];
      img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h10; img[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        ram[32'h100 + 32'(i)] = img[i]; gm[32'h100 + 32'(i)] = img[i];
      end
      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
        ram[32'h40 + 32'(i)] = img[i]; gm[32'h40 + 32'(i)] = img[i];
      end
    end
    ram[32'h20] = 8'hFF; gm[32'h20] = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      ram[32'h300 + 32'(i)] = b; gm[32'h300 + 32'(i)] = b;
    end

    #2;
    chk("reset ram_a", ram_a, 32'h0);
    chk("reset strobes", {27'b0, ram_wr, if_done, mem_done, mem_busy, 1'b0}, 32'h0);
    chk("reset data", if_data | mem_data | {24'b0, ram_dout}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{0, 32'h100,      2'd0, 32'h0,    32'h00100513};
    tbl[1] = '{1, 32'h20,       2'd0, 32'h0,    32'h000000FF};
    tbl[2] = '{1, 32'h40,       2'd1, 32'h0,    32'h00002211};
    tbl[3] = '{1, 32'h40,       2'd2, 32'h0,    32'h44332211};
    tbl[4] = '{1, 32'h41,       2'd3, 32'h0,    32'h00443322};
    tbl[5] = '{2, 32'hFFFFFFFF, 2'd1, 32'hABCD, 32'h0};
    tbl[6] = '{1, 32'hFFFFFFFF, 2'd1, 32'h0,    32'h0000ABCD};
    tbl[7] = '{1, 32'hFFFFFFFE, 2'd3, 32'h0,    32'h00ABCD00};
    for (int v = 0; v < 8; v++)
      do_txn(tbl[v].kind, tbl[v].addr, tbl[v].len, tbl[v].wd, 0, tbl[v].exp, $sformatf("vec%0d", v));

    // simultaneous requests: MEM first, IF after the turnaround cycle
    if_req = 1; if_addr = 32'h100; mem_req = 1; mem_we = 0; mem_addr = 32'h20; mem_len = 0;
    @(posedge clk); @(negedge clk);
    chk("prio mem first", ram_a, 32'h20);
    chk("prio busy", {31'b0, mem_busy}, 32'd1);
    mem_req = 0;
    @(posedge clk); @(negedge clk);
    chk("prio mem_done", {31'b0, mem_done}, 32'd1);
    chk("prio mem_data", mem_data, 32'h000000FF);
    @(posedge clk); @(negedge clk);
    chk("prio turnaround idle", ram_a, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("prio if accepted", ram_a, 32'h100);
    if_req = 0; mem_req = 1; mem_addr = 32'h40;
    #1 chk("busy while IF", {31'b0, mem_busy}, 32'd1);
    mem_req = 0;
    #1 chk("busy released", {31'b0, mem_busy}, 32'd0);
    for (int k = 0; k < 20 && !if_done; k++) begin @(posedge clk); @(negedge clk); end
    chk("prio if_done", {31'b0, if_done}, 32'd1);
    chk("prio if_data", if_data, 32'h00100513);
    last_mem = 32'hFF; last_if = 32'h00100513;
    @(posedge clk); @(negedge clk);

    // rdy low three cycles on the second byte of a word load
    do_txn(1, 32'h40, 2'd3, 32'h0, 2, 32'h44332211, "stall");

    // reset during the third byte of a store
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_len = 3; mem_wdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    mem_req = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst pre ram_a", ram_a, 32'h202);
    chk("rst pre ram_wr", {31'b0, ram_wr}, 32'd1);
    #1 rst = 1;
    #1 chk("rst ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst ram_a", ram_a, 32'h0);
    chk("rst outputs", {29'b0, mem_done, mem_busy, if_done}, 32'h0);
    @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_done) pulses++;
    end
    chk("rst no done", pulses, 0);
    chk("rst byte2 unwritten", {24'b0, rd_ram(32'h202)}, 32'h0);
    chk("rst byte1 written", {24'b0, rd_ram(32'h201)}, 32'hBE);
    gm[32'h200] = 8'hEF; gm[32'h201] = 8'hBE;
    last_if = '0; last_mem = '0;
    do_txn(1, 32'h200, 2'd3, 32'h0, 0, 32'h0000BEEF, "post-rst");

    // branch abort with cnt=2
    if_req = 1; if_addr = 32'h100;
    @(posedge clk); @(negedge clk);
    if_req = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort pre ram_a", ram_a, 32'h102);
    if_abort = 1;
`ifdef MEMCTRL_IF_ABORT_EN
    mem_req = 1; mem_we = 0; mem_addr = 32'h20; mem_len = 0;
`endif
    @(posedge clk); @(negedge clk);
    if_abort = 0;
    chk("abort no early done", {31'b0, if_done}, 32'd0);
`ifdef MEMCTRL_IF_ABORT_EN
    chk("abort idle", ram_a, 32'h0);
    @(posedge clk); @(negedge clk);
    mem_req = 0;
    chk("abort mem accepted", ram_a, 32'h20);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (if_done) pulses++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort no if_done", pulses, 0);
    chk("abort if_data hold", if_data, 32'h0);
    last_mem = 32'hFF;
`else
    chk("no-abort continues", ram_a, 32'h103);
    @(posedge clk); @(negedge clk);
    chk("no-abort if_done", {31'b0, if_done}, 32'd1);
    chk("no-abort if_data", if_data, 32'h00100513);
    last_if = 32'h00100513;
    @(posedge clk); @(negedge clk);
`endif

    // random transactions against the golden map
    for (int t = 0; t < 60; t++) begin
      int          kind;
      logic [31:0] a, wd;
      logic [1:0]  len;
      kind = int'($urandom % 3);
      a    = ($urandom % 4 == 0) ? 32'hFFFFFFFC + ($urandom % 4) : 32'h300 + ($urandom % 60);
      len  = 2'($urandom);
      wd   = $urandom;
      do_txn(kind, a, len, wd, 1, model_read(a, nbytes(kind, len)), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
